// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSB-first serialisation, bit stuffing, NRZI, EOP.
// Optional macro USB_TX_CRC16_EN appends a bit-stuffed CRC16 trailer after the last byte.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus_out,
   output logic       d_minus_out,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [3:0]    idx_q, idx_n, nxt_idx;
   logic [2:0]    ones_q, ones_n;
   logic [7:0]    byte_q, byte_n;
   logic          last_q, last_n;
   logic          dp_q, dp_n, dm_q, dm_n;
   logic          bnd, fetch, launch, lbit;

`ifdef USB_TX_CRC16_EN
   logic [15:0]   crc_q, crc_n;
   logic          in_crc_q, in_crc_n, pid_q, pid_n, data_bit;

   // Reflected form of polynomial 0x8005, fed LSB-first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 16'hA001 : 16'h0000);
   endfunction
`endif

   assign bnd     = (cnt_q == CNT_MAX);
   assign nxt_idx = idx_q + 4'd1;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         ones_q   <= '0;
         byte_q   <= '0;
         last_q   <= 1'b0;
         dp_q     <= 1'b1;
         dm_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_q    <= '0;
         in_crc_q <= 1'b0;
         pid_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_n;
         cnt_q    <= cnt_n;
         idx_q    <= idx_n;
         ones_q   <= ones_n;
         byte_q   <= byte_n;
         last_q   <= last_n;
         dp_q     <= dp_n;
         dm_q     <= dm_n;
`ifdef USB_TX_CRC16_EN
         crc_q    <= crc_n;
         in_crc_q <= in_crc_n;
         pid_q    <= pid_n;
`endif
      end
   end

   // State reflects the bit currently on the line; every decision is taken on the wrap clock.
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      idx_n    = idx_q;
      ones_n   = ones_q;
      byte_n   = byte_q;
      last_n   = last_q;
      dp_n     = dp_q;
      dm_n     = dm_q;
      fetch    = 1'b0;
      launch   = 1'b0;
      lbit     = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_n    = crc_q;
      in_crc_n = in_crc_q;
      pid_n    = pid_q;
      data_bit = 1'b0;
`endif
      if (state_q != IDLE) cnt_n = bnd ? '0 : cnt_q + CW'(1);

      case (state_q)
         IDLE: begin
            if (tx_valid) begin
               byte_n  = tx_data;
               last_n  = tx_last;
               state_n = SYNC;
               idx_n   = '0;
               cnt_n   = '0;
               launch  = 1'b1;
`ifdef USB_TX_CRC16_EN
               pid_n    = 1'b1;
               crc_n    = 16'hFFFF;
               in_crc_n = 1'b0;
`endif
            end
         end
         SYNC: begin
            if (bnd) begin
               launch = 1'b1;
               if (idx_q == 4'd7) begin
                  state_n = DATA;
                  idx_n   = '0;
                  lbit    = byte_q[0];
`ifdef USB_TX_CRC16_EN
                  data_bit = 1'b1;
`endif
               end else begin
                  idx_n = nxt_idx;
                  lbit  = (nxt_idx == 4'd7);
               end
            end
         end
         DATA, STUFF: begin
            if (bnd) begin
               if (state_q == DATA && ones_q == 3'd6) begin
                  state_n = STUFF;
                  launch  = 1'b1;
               end
`ifdef USB_TX_CRC16_EN
               else if (in_crc_q) begin
                  if (idx_q == 4'd15) begin
                     state_n = EOP_SE0;
                     idx_n   = '0;
                     dp_n    = 1'b0;
                     dm_n    = 1'b0;
                  end else begin
                     state_n = DATA;
                     idx_n   = nxt_idx;
                     launch  = 1'b1;
                     lbit    = crc_q[nxt_idx];
                  end
               end
`endif
               else if (idx_q != 4'd7) begin
                  state_n = DATA;
                  idx_n   = nxt_idx;
                  launch  = 1'b1;
                  lbit    = byte_q[nxt_idx[2:0]];
`ifdef USB_TX_CRC16_EN
                  data_bit = 1'b1;
`endif
               end else if (last_q) begin
`ifdef USB_TX_CRC16_EN
                  state_n  = DATA;
                  in_crc_n = 1'b1;
                  idx_n    = '0;
                  crc_n    = ~crc_q;
                  launch   = 1'b1;
                  lbit     = ~crc_q[0];
`else
                  state_n = EOP_SE0;
                  idx_n   = '0;
                  dp_n    = 1'b0;
                  dm_n    = 1'b0;
`endif
               end else begin
                  fetch = 1'b1;
                  idx_n = '0;
                  if (tx_valid) begin
                     byte_n  = tx_data;
                     last_n  = tx_last;
                     state_n = DATA;
                     launch  = 1'b1;
                     lbit    = tx_data[0];
`ifdef USB_TX_CRC16_EN
                     pid_n    = 1'b0;
                     data_bit = 1'b1;
`endif
                  end else begin
                     state_n = EOP_SE0;
                     dp_n    = 1'b0;
                     dm_n    = 1'b0;
                  end
               end
            end
         end
         EOP_SE0: begin
            if (bnd) begin
               if (idx_q == 4'd1) begin
                  state_n = EOP_J;
                  idx_n   = '0;
                  dp_n    = 1'b1;
                  dm_n    = 1'b0;
               end else begin
                  idx_n = nxt_idx;
               end
            end
         end
         EOP_J: begin
            if (bnd) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // NRZI: a 0 toggles J/K, a 1 holds the line and extends the run of ones.
      if (launch) begin
         if (!lbit) begin
            dp_n   = ~dp_q;
            dm_n   = ~dm_q;
            ones_n = '0;
         end else begin
            ones_n = ones_q + 3'd1;
         end
      end
`ifdef USB_TX_CRC16_EN
      if (data_bit && !pid_n) crc_n = crc_step(crc_q, lbit);
`endif
   end

   assign d_plus_out  = dp_q;
   assign d_minus_out = dm_q;
   assign tx_busy     = (state_q != IDLE);
   assign tx_ready    = n_rst & ((state_q == IDLE) | fetch);
   assign tx_err      = n_rst & fetch & ~tx_valid;
   assign tx_done     = n_rst & (state_q == EOP_J) & bnd;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Self-checking bench for usb_tx_encoder: directed and random packets against a bit-stream model.
// The model honours USB_TX_CRC16_EN when the bench is built with it.
module tb_usb_tx_encoder;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       n_rst, tx_valid, tx_last;
   logic [7:0] tx_data;
   logic       tx_ready, d_plus_out, d_minus_out, tx_busy, tx_done, tx_err;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] pkt[$];
   logic [1:0] exp_line[$];
   int         fetch_l[$];
   int         err_l;
   bit         stream[$];
   int         run_ones;

   always #5 clk = ~clk;

   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_ready   (tx_ready),
      .d_plus_out (d_plus_out),
      .d_minus_out(d_minus_out),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err)
   );

   function automatic logic [5:0] outs();
      return {d_plus_out, d_minus_out, tx_ready, tx_busy, tx_done, tx_err};
   endfunction

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: {dp,dm,ready,busy,done,err} observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Appends a bit to the transmitted stream, inserting a 0 after six consecutive ones.
   task automatic push_bit(input bit b);
      stream.push_back(b);
      run_ones = b ? run_ones + 1 : 0;
      if (run_ones == 6) begin
         stream.push_back(1'b0);
         run_ones = 0;
      end
   endtask

   task automatic build_model(input bit underrun);
      logic lvl;
`ifdef USB_TX_CRC16_EN
      logic [15:0] r;
`endif
      stream.delete();
      fetch_l.delete();
      exp_line.delete();
      run_ones = 0;
      err_l    = -1;
      for (int i = 0; i < 8; i++) push_bit(i == 7);
      foreach (pkt[k]) begin
         for (int i = 0; i < 8; i++) push_bit(pkt[k][i]);
         if (underrun || k != pkt.size() - 1) fetch_l.push_back(stream.size());
      end
      if (underrun) err_l = fetch_l[fetch_l.size() - 1];
`ifdef USB_TX_CRC16_EN
      // Non-reflected division in transmission order; sending ~r MSB-first equals the reflected remainder LSB-first.
      if (!underrun) begin
         r = 16'hFFFF;
         for (int k = 1; k < pkt.size(); k++)
            for (int i = 0; i < 8; i++)
               r = {r[14:0], 1'b0} ^ (((r[15] ^ pkt[k][i]) == 1'b1) ? 16'h8005 : 16'h0000);
         for (int i = 15; i >= 0; i--) push_bit(~r[i]);
      end
`endif
      lvl = 1'b1;
      foreach (stream[j]) begin
         if (!stream[j]) lvl = ~lvl;
         exp_line.push_back({lvl, ~lvl});
      end
      exp_line.push_back(2'b00);
      exp_line.push_back(2'b00);
      exp_line.push_back(2'b10);
   endtask

   // Cycle 0 is the acceptance cycle; bit j of the line occupies cycles 1+j*CPB .. (j+1)*CPB.
   function automatic logic [5:0] expect_at(input int c, input int nb);
      logic rdy;
      if (c == 0 || c > nb * CPB) return 6'b101000;
      rdy = 1'b0;
      foreach (fetch_l[i]) if (c == fetch_l[i] * CPB) rdy = 1'b1;
      return {exp_line[(c - 1) / CPB], rdy, 1'b1, (c == nb * CPB), (c == err_l * CPB)};
   endfunction

   task automatic run_packet(input bit underrun, input string name);
      int idx;
      int nb;
      bit acc;
      idx = 0;
      build_model(underrun);
      nb = exp_line.size();
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = pkt[0];
      tx_last  = !underrun && pkt.size() == 1;
      for (int c = 0; c <= nb * CPB + 1; c++) begin
         @(negedge clk);
         check($sformatf("%s c%0d", name, c), outs(), expect_at(c, nb));
         acc = tx_ready && tx_valid;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < pkt.size()) begin
               tx_data = pkt[idx];
               tx_last = !underrun && idx == pkt.size() - 1;
            end else begin
               tx_valid = 1'b0;
               tx_last  = 1'b0;
               tx_data  = 8'($urandom);
            end
         end
      end
   endtask

   initial begin
      n_rst    = 1'b0;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset", outs(), 6'b100000);
      @(posedge clk); #1;
      n_rst = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check($sformatf("idle%0d", i), outs(), 6'b101000);
      end

      pkt = '{8'hFF};
      run_packet(1'b0, "ff");
      pkt = '{8'hC3, 8'h00};
      run_packet(1'b0, "c3_00");
      pkt = '{8'h4B};
      run_packet(1'b1, "underrun");
      pkt = '{8'hC3};
      run_packet(1'b0, "pid_only");

      // Reset asserted during the third data bit of a packet.
      pkt = '{8'h55};
      build_model(1'b0);
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      tx_last  = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (83) @(posedge clk);
      #1;
      @(negedge clk);
      check("mid_line", outs(), {exp_line[10], 4'b0100});
      n_rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst", outs(), 6'b100000);
      @(posedge clk); #1;
      n_rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check($sformatf("post_rst%0d", i), outs(), 6'b101000);
      end
      pkt = '{8'hA5, 8'h3C};
      run_packet(1'b0, "after_rst");

      for (int t = 0; t < 16; t++) begin
         int n;
         pkt.delete();
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       pkt.push_back(8'hFF);
               1:       pkt.push_back(8'hFE);
               default: pkt.push_back(8'($urandom));
            endcase
         end
         run_packet($urandom_range(0, 4) == 0, $sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
